// File: rtl/uart_rx.sv
// uart_rx -- asynchronous serial receiver, MSB first, optional parity,
// one or two stop bits, single-byte holding register with overrun detection.
//
// Parameters
//   MODOS_DE_OPERACAO [7:6] baud select, [5] stop bits (0 = two, 1 = one),
//                     [1] parity sense (0 = even, 1 = odd), [0] parity enable
//   DIV_OVERRIDE      nonzero replaces the baud-table divider
// Ports
//   Clock         system clock, rising edge
//   Reset_n       synchronous reset, active-low
//   DATA_IN       asynchronous serial line, idle high
//   READ          one-cycle pulse, consumer took DATA_OUT
//   DATA_OUT      last received byte
//   DATA_VALID    one-cycle pulse, new byte committed
//   ERRO_PARIDADE parity error of the byte in DATA_OUT
//   ERRO_FRAME    stop-bit error of the byte in DATA_OUT
//   OVERRUN       sticky, a byte was committed while the holding register was full
//   CTS           high when the holding register is empty
module uart_rx #(
    parameter logic [7:0]  MODOS_DE_OPERACAO = 8'b10110101,
    parameter logic [15:0] DIV_OVERRIDE      = 16'd0
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       DATA_IN,
    input  logic       READ,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       ERRO_PARIDADE,
    output logic       ERRO_FRAME,
    output logic       OVERRUN,
    output logic       CTS
);

    localparam logic [15:0] DIV_TABLE =
        (MODOS_DE_OPERACAO[7:6] == 2'b00) ? 16'd10416 :
        (MODOS_DE_OPERACAO[7:6] == 2'b01) ? 16'd5208  :
        (MODOS_DE_OPERACAO[7:6] == 2'b10) ? 16'd2604  : 16'd868;
    localparam logic [15:0] DIV      = (DIV_OVERRIDE != 16'd0) ? DIV_OVERRIDE : DIV_TABLE;
    localparam logic [15:0] HALF     = DIV >> 1;
    localparam logic        PAR_EN   = MODOS_DE_OPERACAO[0];
    localparam logic        PAR_ODD  = MODOS_DE_OPERACAO[1];
    localparam logic        ONE_STOP = MODOS_DE_OPERACAO[5];

    // D7..D0 are consecutive so a data state advances by incrementing.
    typedef enum logic [3:0] {
        IDLE, START, D7, D6, D5, D4, D3, D2, D1, D0,
        PARIDADE, STOPBIT1, STOPBIT2, COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        armed_q, armed_d;
    logic        sync1_q, sync2_q;
    logic [1:0]  warm_q;
    logic [7:0]  dout_q;
    logic        dv_q, eperr_q, eferr_q, ovr_q, full_q;
    logic        load;
    logic        rx;
    logic        bit_end;

    assign rx      = sync2_q;
    assign bit_end = (cnt_q == DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                // The synchronizer flops come out of reset holding 1, so a
                // high level only counts once real line samples have reached
                // sync2_q. This keeps a line held low through reset from
                // looking like a falling edge.
                if (warm_q == 2'd2 && rx) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx) begin
                    state_d = START;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = 16'd0;
                    state_d = rx ? IDLE : D7;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            D7, D6, D5, D4, D3, D2, D1: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    shift_d = {shift_q[6:0], rx};
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            D0: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    shift_d = {shift_q[6:0], rx};
                    state_d = PAR_EN ? PARIDADE : STOPBIT1;
                end
            end
            PARIDADE: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    if (rx != ((^shift_q) ^ PAR_ODD)) begin
                        perr_d = 1'b1;
                    end
                    state_d = STOPBIT1;
                end
            end
            STOPBIT1: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    if (!rx) begin
                        ferr_d = 1'b1;
                    end
                    state_d = ONE_STOP ? COMMIT : STOPBIT2;
                    load    = ONE_STOP;
                end
            end
            STOPBIT2: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    if (!rx) begin
                        ferr_d = 1'b1;
                    end
                    state_d = COMMIT;
                    load    = 1'b1;
                end
            end
            COMMIT: begin
                cnt_d   = 16'd0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Output registers are loaded on the edge into COMMIT so that the byte,
    // its flags and the DATA_VALID pulse are all visible during COMMIT.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            shift_q <= 8'h00;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            warm_q  <= 2'd0;
            dout_q  <= 8'h00;
            dv_q    <= 1'b0;
            eperr_q <= 1'b0;
            eferr_q <= 1'b0;
            ovr_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            sync1_q <= DATA_IN;
            sync2_q <= sync1_q;
            if (warm_q != 2'd2) begin
                warm_q <= warm_q + 2'd1;
            end
            dv_q <= load;
            if (load) begin
                dout_q  <= shift_q;
                eperr_q <= PAR_EN & perr_d;
                eferr_q <= ferr_d;
                full_q  <= 1'b1;
                // A simultaneous READ consumes the old byte, so the overwrite
                // is not an overrun.
                if (full_q && !READ) begin
                    ovr_q <= 1'b1;
                end else if (full_q && READ) begin
                    ovr_q <= 1'b0;
                end
            end else if (READ && full_q) begin
                full_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    assign DATA_OUT      = dout_q;
    assign DATA_VALID    = dv_q;
    assign ERRO_PARIDADE = eperr_q;
    assign ERRO_FRAME    = eferr_q;
    assign OVERRUN       = ovr_q;
    assign CTS           = !full_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx with a 16-clock bit period,
// even parity and one stop bit. Frames are generated from their byte value;
// the expected byte/flags are queued at issue and checked when DATA_VALID
// pulses.
module tb_uart_rx;

    localparam int BIT = 16;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       DATA_IN = 1'b1;
    logic       READ = 1'b0;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       ERRO_PARIDADE;
    logic       ERRO_FRAME;
    logic       OVERRUN;
    logic       CTS;

    uart_rx #(
        .MODOS_DE_OPERACAO(8'b10110101),
        .DIV_OVERRIDE     (16'd15)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .DATA_IN      (DATA_IN),
        .READ         (READ),
        .DATA_OUT     (DATA_OUT),
        .DATA_VALID   (DATA_VALID),
        .ERRO_PARIDADE(ERRO_PARIDADE),
        .ERRO_FRAME   (ERRO_FRAME),
        .OVERRUN      (OVERRUN),
        .CTS          (CTS)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Holding-register model: whether an unread byte is held, and the
    // sticky overrun flag.
    logic full_m = 1'b0;
    logic ovr_m  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        DATA_IN = b;
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic sbad);
        exp_t e;
        e.data = d;
        e.perr = pflip;
        e.ferr = sbad;
        e.ovr  = ovr_m | full_m;
        ovr_m  = e.ovr;
        full_m = 1'b1;
        exp_q.push_back(e);
        drive_bit(1'b0, BIT);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(d[i], BIT);
        end
        drive_bit((^d) ^ pflip, BIT);
        if (sbad) begin
            drive_bit(1'b0, 40);
        end else begin
            drive_bit(1'b1, BIT);
        end
        drive_bit(1'b1, 2 * BIT);
    endtask

    task automatic do_read();
        READ = 1'b1;
        @(negedge Clock);
        READ = 1'b0;
        if (full_m) begin
            full_m = 1'b0;
            ovr_m  = 1'b0;
        end
        chk("read_overrun", {31'd0, OVERRUN}, {31'd0, ovr_m});
        chk("read_cts", {31'd0, CTS}, {31'd0, !full_m});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_data_out"}, {24'd0, DATA_OUT}, 32'h00);
        chk({tag, "_valid"}, {31'd0, DATA_VALID}, 32'd0);
        chk({tag, "_perr"}, {31'd0, ERRO_PARIDADE}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, ERRO_FRAME}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, OVERRUN}, 32'd0);
        chk({tag, "_cts"}, {31'd0, CTS}, 32'd1);
    endtask

    // Monitor: every DATA_VALID cycle must match the oldest queued frame.
    always @(negedge Clock) begin
        if (DATA_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got DATA_OUT=%0h with no frame pending at %0t", DATA_OUT, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_data", {24'd0, DATA_OUT}, {24'd0, e.data});
                chk("mon_perr", {31'd0, ERRO_PARIDADE}, {31'd0, e.perr});
                chk("mon_ferr", {31'd0, ERRO_FRAME}, {31'd0, e.ferr});
                chk("mon_overrun", {31'd0, OVERRUN}, {31'd0, e.ovr});
                chk("mon_cts", {31'd0, CTS}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] mid;
        logic       pf;
        logic       sb;

        Reset_n = 1'b0;
        DATA_IN = 1'b1;
        repeat (3) @(negedge Clock);
        check_reset_vals("reset");
        Reset_n = 1'b1;
        drive_bit(1'b1, 2 * BIT);

        // Clean frame, then bad parity, then good parity again.
        send_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        do_read();

        // Stop bit held low, then a normal frame.
        send_frame(8'h0F, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        do_read();

        // Short low glitch must not produce a byte.
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 3 * BIT);
        send_frame(8'h5A, 1'b0, 1'b0);
        do_read();

        // Overrun: two frames without a read.
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        chk("overrun_data", {24'd0, DATA_OUT}, 32'h22);
        chk("overrun_flag", {31'd0, OVERRUN}, 32'd1);
        do_read();

        // Reset in the middle of the D3 bit of 0x99.
        mid = 8'h99;
        drive_bit(1'b0, BIT);
        for (int i = 7; i >= 4; i--) begin
            drive_bit(mid[i], BIT);
        end
        drive_bit(mid[3], 2);
        Reset_n = 1'b0;
        @(negedge Clock);
        full_m = 1'b0;
        ovr_m  = 1'b0;
        check_reset_vals("midreset");
        Reset_n = 1'b1;
        drive_bit(1'b1, 3 * BIT);
        send_frame(8'h99, 1'b0, 1'b0);
        do_read();

        // Randomized frames with random errors, gaps and reads.
        for (int n = 0; n < 12; n++) begin
            rd = 8'($urandom_range(0, 255));
            pf = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) == 0);
            send_frame(rd, pf, sb);
            drive_bit(1'b1, $urandom_range(1, 40));
            if ($urandom_range(0, 1) == 1) begin
                do_read();
            end
        end

        drive_bit(1'b1, 4 * BIT);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter MODOS_DE_OPERACAO, default 8'b10110101: [7:6] baud select, [5] stop bits (0 = two, 1 = one), [1] parity sense (0 = even, 1 = odd), [0] parity enable; bits [4:2] are ignored.
REQ-002 SHALL have parameter DIV_OVERRIDE, default 16'd0: when nonzero, it replaces the baud table value DIV.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  synchronous reset, active-low.
- DATA_IN  in  1  asynchronous serial line; idle high; MSB first.
- READ  in  1  one-cycle pulse; consumer has taken DATA_OUT.
- DATA_OUT  out  8  last received byte.
- DATA_VALID  out  1  one-cycle pulse; new byte committed.
- ERRO_PARIDADE  out  1  parity error of the byte in DATA_OUT.
- ERRO_FRAME  out  1  stop-bit error of the byte in DATA_OUT.
- OVERRUN  out  1  sticky; a byte was committed while the holding register was full.
- CTS  out  1  clear-to-send to the remote transmitter; 1 when the holding register is empty.

Function
REQ-005 DIV SHALL be 10416/5208/2604/868 for MODOS_DE_OPERACAO[7:6] = 00/01/10/11; bit period SHALL be DIV+1 clocks (16-bit counter runs 0..DIV, then wraps to 0).
REQ-006 DATA_IN SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-007 FSM states SHALL be IDLE, START, D7, D6, D5, D4, D3, D2, D1, D0, PARIDADE, STOPBIT1, STOPBIT2, COMMIT.
REQ-008 IDLE: a synchronized high-to-low transition SHALL move to START with the counter cleared. A line already low at reset exit SHALL NOT start a frame until it has been seen high.
REQ-009 START: at counter == DIV/2 (integer divide), the line SHALL be sampled.
- Line 0: go to D7 and clear the counter.
- Line 1: false start; return to IDLE with no output change.
REQ-010 D7..D0: each state SHALL sample at counter == DIV into shift bit 7..0, then advance.
- After D0: go to PARIDADE if [0]=1, else STOPBIT1.
REQ-011 PARIDADE: the sampled bit SHALL be compared with the expected value (XOR-reduce of the 8 data bits) XOR [1]; a mismatch sets a pending parity error. Next state is STOPBIT1.
REQ-012 STOPBIT1: the line SHALL be sampled at counter == DIV; a 0 sets a pending frame error.
- Next state: STOPBIT2 if [5]=0, else COMMIT.
REQ-013 STOPBIT2: SHALL sample the same way as STOPBIT1, then go to COMMIT.
REQ-014 COMMIT (exactly one cycle) SHALL update outputs and then go to IDLE:
- Load DATA_OUT.
- Load ERRO_PARIDADE and ERRO_FRAME from the pending flags (parity error forced 0 when [0]=0).
- Pulse DATA_VALID.
- Clear the pending flags.
REQ-015 DATA_VALID SHALL be asserted in the cycle after the final stop-bit sample.
REQ-016 The holding register SHALL be full from COMMIT until READ; CTS = !full.
REQ-017 On COMMIT while full, the new byte SHALL overwrite DATA_OUT and OVERRUN SHALL be set.
- OVERRUN clears only on READ.
- If READ and COMMIT occur in the same cycle, COMMIT wins: full = 1 and OVERRUN is not set.
REQ-018 READ while empty SHALL have no effect.
REQ-019 A frame error SHALL NOT block reception: in IDLE, a line held low after the error SHALL wait for a high level before re-arming.

Reset
REQ-020 With Reset_n = 0 at a clock edge, the block SHALL reset as follows:
- State goes to IDLE; counter, shift register and pending flags clear.
- DATA_OUT = 8'h00; DATA_VALID, ERRO_PARIDADE, ERRO_FRAME and OVERRUN = 0.
- CTS = 1 and both synchronizer flops = 1.
REQ-021 Reset mid-frame SHALL abort the frame with no DATA_VALID and no partial DATA_OUT update.

Verification (DIV_OVERRIDE = 15, default mode: 16-clock bit, even parity, one stop bit)
REQ-022 Frame 0xA5 with parity 0 and stop 1 -> DATA_OUT = 8'hA5, one DATA_VALID pulse, both error flags 0, CTS falls to 0.
REQ-023 0xA5 with parity bit 1 -> DATA_OUT = 8'hA5, ERRO_PARIDADE = 1; then a 0x3C frame with correct parity -> ERRO_PARIDADE = 0.
REQ-024 0x0F with stop bit 0 held for 40 clocks, then high -> ERRO_FRAME = 1; the next 0x55 frame is received correctly.
REQ-025 DATA_IN low glitch of 5 clocks -> no DATA_VALID, FSM back in IDLE, next frame is received normally.
REQ-026 0x11 then 0x22 with no READ -> DATA_OUT = 8'h22, OVERRUN = 1; READ -> OVERRUN = 0, CTS = 1.
REQ-027 Reset_n low for 1 cycle during D3 of 0x99 -> all outputs at reset values, no DATA_VALID; the following 0x99 frame is received correctly.
